// File: rtl/key_event_decoder_if.sv
// rtl/key_event_decoder_if.sv - key level input and gesture event outputs of the key event decoder
interface key_event_decoder_if;
  logic [1:0] key_filter;
  logic [1:0] key_short;
  logic [1:0] key_long;
  logic [1:0] key_double;

  modport master (
    output key_filter,
    input  key_short,
    input  key_long,
    input  key_double
  );

  modport slave (
    input  key_filter,
    output key_short,
    output key_long,
    output key_double
  );
endinterface

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - per-key short/long/double-click gesture decoder
// Double-click detection is built only when KEY_DOUBLE_EN is defined.
module key_event_decoder #(
  parameter int LONG_CNT   = 25_000_000,
  parameter int DCLICK_CNT = 15_000_000,
  parameter int CNT_W      = 25
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  key_event_decoder_if.slave key_if
);

`ifdef KEY_DOUBLE_EN
  typedef enum logic [1:0] {IDLE, PRESS, HELD, WAIT2} state_t;
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CNT - 1);
`else
  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;
`endif

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic             key_d;
    logic             key_press;
    logic             key_release;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             short_d;
    logic             short_q;
    logic             long_d;
    logic             long_q;
`ifdef KEY_DOUBLE_EN
    logic             double_d;
    logic             double_q;
`endif

    assign key_press   = key_d & ~key_if.key_filter[k];
    assign key_release = ~key_d & key_if.key_filter[k];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      short_d = 1'b0;
      long_d  = 1'b0;
`ifdef KEY_DOUBLE_EN
      double_d = 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (key_press) begin
            state_d = PRESS;
            cnt_d   = '0;
          end
        end
        PRESS: begin
          cnt_d = cnt_q + 1'b1;
          // a release on the long-press edge still counts as a short press
          if (key_release) begin
            cnt_d = '0;
`ifdef KEY_DOUBLE_EN
            state_d = WAIT2;
`else
            short_d = 1'b1;
            state_d = IDLE;
`endif
          end else if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        HELD: begin
          cnt_d = '0;
          if (key_release) begin
            state_d = IDLE;
          end
        end
`ifdef KEY_DOUBLE_EN
        WAIT2: begin
          cnt_d = cnt_q + 1'b1;
          // second press wins over window expiry; its hold yields no further event
          if (key_press) begin
            double_d = 1'b1;
            state_d  = HELD;
            cnt_d    = '0;
          end else if (cnt_q == DCLICK_LAST) begin
            short_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        key_d   <= 1'b1;
        state_q <= IDLE;
        cnt_q   <= '0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
`ifdef KEY_DOUBLE_EN
        double_q <= 1'b0;
`endif
      end else begin
        key_d   <= key_if.key_filter[k];
        state_q <= state_d;
        cnt_q   <= cnt_d;
        short_q <= short_d;
        long_q  <= long_d;
`ifdef KEY_DOUBLE_EN
        double_q <= double_d;
`endif
      end
    end
  end

  assign key_if.key_short = {g_key[1].short_q, g_key[0].short_q};
  assign key_if.key_long  = {g_key[1].long_q, g_key[0].long_q};
`ifdef KEY_DOUBLE_EN
  assign key_if.key_double = {g_key[1].double_q, g_key[0].double_q};
`else
  assign key_if.key_double = 2'b00;
`endif

endmodule
